// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan controller: one digit per slot, dead time at slot
// start, frame-synchronous value update, blanking, decimal points, leading-zero suppression.
module seg_scan_driver #(
  parameter int N_DIGITS         = 8,
  parameter int REFRESH_DIV      = 100000,
  parameter int BLANK_CYCLES     = 64,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                        i_mclk,
  input  logic                        i_reset_n,
  input  logic                        i_en,
  input  logic                        i_load,
  input  logic [4*N_DIGITS-1:0]       i_value,
  input  logic [N_DIGITS-1:0]         i_dp,
  input  logic [N_DIGITS-1:0]         i_blank,
  input  logic                        i_lz_suppress,
  output logic [7:0]                  o_seg,
  output logic [N_DIGITS-1:0]         o_an,
  output logic [$clog2(N_DIGITS)-1:0] o_digit_idx,
  output logic                        o_frame_done
);

  localparam int IW = $clog2(N_DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_DIGITS - 1);
  localparam logic [PW-1:0] LAST_PRE  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
  localparam logic [PW-1:0] PRE_ONE   = PW'(1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t                state, nxt_state;
  logic [PW-1:0]         prescaler, nxt_prescaler;
  logic [IW-1:0]         nxt_idx;
  logic                  slot0_entry, wrap;

  logic [4*N_DIGITS-1:0] disp_value, nxt_disp_value, pend_value, nxt_pend_value;
  logic [N_DIGITS-1:0]   disp_dp, nxt_disp_dp, pend_dp, nxt_pend_dp;
  logic [N_DIGITS-1:0]   disp_blank, nxt_disp_blank, pend_blank, nxt_pend_blank;
  logic                  pend_flag, nxt_pend_flag;

  logic [N_DIGITS-1:0]   upper_zero;
  logic                  zero_acc;
  logic [3:0]            nibble;
  logic [7:0]            seg_raw;
  logic [N_DIGITS-1:0]   an_raw;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  // Outputs are registered from the next-state view so they line up with the state they describe.
  always_comb begin
    nxt_pend_value = pend_value;
    nxt_pend_dp    = pend_dp;
    nxt_pend_blank = pend_blank;
    nxt_pend_flag  = pend_flag;
    if (i_load) begin
      nxt_pend_value = i_value;
      nxt_pend_dp    = i_dp;
      nxt_pend_blank = i_blank;
      nxt_pend_flag  = 1'b1;
    end

    nxt_state     = state;
    nxt_prescaler = prescaler;
    nxt_idx       = o_digit_idx;
    slot0_entry   = 1'b0;
    wrap          = 1'b0;
    if (!i_en) begin
      nxt_state     = IDLE;
      nxt_prescaler = '0;
      nxt_idx       = '0;
    end else if (state == IDLE) begin
      nxt_state     = BLANK;
      nxt_prescaler = '0;
      nxt_idx       = '0;
      slot0_entry   = 1'b1;
    end else if (prescaler == LAST_PRE) begin
      nxt_state     = BLANK;
      nxt_prescaler = '0;
      if (o_digit_idx == LAST_IDX) begin
        nxt_idx     = '0;
        wrap        = 1'b1;
        slot0_entry = 1'b1;
      end else begin
        nxt_idx = o_digit_idx + IDX_ONE;
      end
    end else begin
      nxt_prescaler = prescaler + PRE_ONE;
      nxt_state     = ((prescaler + PRE_ONE) < BLANK_END) ? BLANK : DRIVE;
    end

    // A load coinciding with slot-0 entry is already in nxt_pend_*, so the newest value wins.
    nxt_disp_value = disp_value;
    nxt_disp_dp    = disp_dp;
    nxt_disp_blank = disp_blank;
    if (slot0_entry && nxt_pend_flag) begin
      nxt_disp_value = nxt_pend_value;
      nxt_disp_dp    = nxt_pend_dp;
      nxt_disp_blank = nxt_pend_blank;
      nxt_pend_flag  = 1'b0;
    end

    zero_acc   = 1'b1;
    upper_zero = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_acc      = zero_acc & (nxt_disp_value[4*k +: 4] == 4'h0);
      upper_zero[k] = zero_acc;
    end

    nibble  = nxt_disp_value[{nxt_idx, 2'b00} +: 4];
    seg_raw = {nxt_disp_dp[nxt_idx], hex_to_seg(nibble)};
    if (i_lz_suppress && (nxt_idx != '0) && upper_zero[nxt_idx])
      seg_raw[6:0] = 7'h00;
    if (nxt_disp_blank[nxt_idx])
      seg_raw = 8'h00;

    an_raw          = '0;
    an_raw[nxt_idx] = 1'b1;
    if (nxt_state != DRIVE) begin
      seg_raw = 8'h00;
      an_raw  = '0;
    end
  end

  always_ff @(posedge i_mclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= IDLE;
      prescaler    <= '0;
      o_digit_idx  <= '0;
      disp_value   <= '0;
      disp_dp      <= '0;
      disp_blank   <= '0;
      pend_value   <= '0;
      pend_dp      <= '0;
      pend_blank   <= '0;
      pend_flag    <= 1'b0;
      o_an         <= {N_DIGITS{ANODE_ACTIVE_LOW}};
      o_seg        <= {8{SEG_ACTIVE_LOW}};
      o_frame_done <= 1'b0;
    end else begin
      state        <= nxt_state;
      prescaler    <= nxt_prescaler;
      o_digit_idx  <= nxt_idx;
      disp_value   <= nxt_disp_value;
      disp_dp      <= nxt_disp_dp;
      disp_blank   <= nxt_disp_blank;
      pend_value   <= nxt_pend_value;
      pend_dp      <= nxt_pend_dp;
      pend_blank   <= nxt_pend_blank;
      pend_flag    <= nxt_pend_flag;
      o_an         <= an_raw ^ {N_DIGITS{ANODE_ACTIVE_LOW}};
      o_seg        <= seg_raw ^ {8{SEG_ACTIVE_LOW}};
      o_frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: stimulus queues expected per-slot outputs,
// a monitor pops and compares on the first DRIVE cycle of every slot.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic        lz = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [1:0]  idx;
  logic        fd;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         id;
    logic [1:0] idx;
    logic [3:0] an;
    logic [7:0] seg;
    int         blank_exp;
  } exp_t;

  exp_t sb[$];

  seg_scan_driver #(
    .N_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2),
    .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .i_mclk(clk), .i_reset_n(rst_n), .i_en(en), .i_load(load),
    .i_value(value), .i_dp(dp), .i_blank(blank), .i_lz_suppress(lz),
    .o_seg(seg), .o_an(an), .o_digit_idx(idx), .o_frame_done(fd)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic report_timeout(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: got no event expected one within bound", name);
  endtask

  task automatic apply_stimulus(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    @(negedge clk);
    load  = 1'b1;
    value = v;
    dp    = d;
    blank = b;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Expected segments are given active-high from the decode table and inverted here.
  task automatic push_slot(input int id, input logic [1:0] d, input logic [7:0] seg_hi, input int blank_exp);
    exp_t e;
    logic [3:0] one_hot;
    one_hot     = 4'b0001 << d;
    e.id        = id;
    e.idx       = d;
    e.an        = ~one_hot;
    e.seg       = ~seg_hi;
    e.blank_exp = blank_exp;
    sb.push_back(e);
  endtask

  task automatic push_frame(input int base, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3, input int first_blank);
    push_slot(base + 0, 2'd0, s0, first_blank);
    push_slot(base + 1, 2'd1, s1, 2);
    push_slot(base + 2, 2'd2, s2, 2);
    push_slot(base + 3, 2'd3, s3, 2);
  endtask

  task automatic wait_frame_done(input string name, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (fd !== 1'b1 && cycles < 200);
    if (fd !== 1'b1) report_timeout(name);
  endtask

  task automatic wait_idx(input logic [1:0] target, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (idx !== target && n < 200);
    if (idx !== target) report_timeout(name);
  endtask

  task automatic wait_an(input logic [3:0] target, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an !== target && n < 200);
    if (an !== target) report_timeout(name);
  endtask

  // Monitor: one comparison set per slot, taken on the first lit cycle after dead time.
  initial begin
    int   dark_cnt = 0;
    bit   prev_dark = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (an !== 4'hF) begin
        if (prev_dark && sb.size() > 0) begin
          e = sb.pop_front();
          check_output($sformatf("slot%0d_idx", e.id), 32'(idx), 32'(e.idx));
          check_output($sformatf("slot%0d_an", e.id), 32'(an), 32'(e.an));
          check_output($sformatf("slot%0d_seg", e.id), 32'(seg), 32'(e.seg));
          if (e.blank_exp != 0)
            check_output($sformatf("slot%0d_deadtime", e.id), 32'(dark_cnt), 32'(e.blank_exp));
        end
        prev_dark = 1'b0;
        dark_cnt  = 0;
      end else begin
        prev_dark = 1'b1;
        dark_cnt++;
      end
    end
  end

  initial begin
    int cyc;
    #1 rst_n = 1'b0;
    #2;
    check_output("reset_an", 32'(an), 32'h0000000F);
    check_output("reset_seg", 32'(seg), 32'h000000FF);
    check_output("reset_idx", 32'(idx), 32'h0);
    check_output("reset_frame_done", 32'(fd), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic scan of 12AF.
    apply_stimulus(16'h12AF, 4'b0000, 4'b0000);
    push_frame(0, 8'h71, 8'h77, 8'h5B, 8'h06, 0);
    en = 1'b1;
    wait_frame_done("frame1_done", cyc);
    check_output("frame_done_idx", 32'(idx), 32'h0);
    check_output("frame_done_dark", 32'(an), 32'h0000000F);
    push_frame(10, 8'h71, 8'h77, 8'h5B, 8'h06, 2);
    wait_frame_done("frame2_done", cyc);
    check_output("frame_period", 32'(cyc), 32'd32);

    // Mid-frame loads leave the current frame untouched; last load wins.
    push_frame(20, 8'h71, 8'h77, 8'h5B, 8'h06, 2);
    wait_idx(2'd2, "wait_digit2");
    apply_stimulus(16'h0000, 4'b0000, 4'b0000);
    apply_stimulus(16'h5555, 4'b0000, 4'b0000);
    wait_frame_done("frame4_done", cyc);
    push_frame(30, 8'h6D, 8'h6D, 8'h6D, 8'h6D, 2);

    // Leading-zero suppression with a dp on a suppressed digit.
    lz = 1'b1;
    apply_stimulus(16'h0070, 4'b1000, 4'b0000);
    wait_frame_done("frame5_done", cyc);
    push_frame(40, 8'h3F, 8'h07, 8'h00, 8'h80, 2);

    // Per-digit blanking overrides the dp.
    apply_stimulus(16'h8888, 4'b0100, 4'b0100);
    wait_frame_done("frame6_done", cyc);
    push_frame(50, 8'h7F, 8'h7F, 8'h00, 8'h7F, 2);
    lz = 1'b0;

    // Drop enable during digit 1 DRIVE.
    wait_frame_done("frame7_done", cyc);
    push_slot(60, 2'd0, 8'h7F, 2);
    push_slot(61, 2'd1, 8'h7F, 2);
    wait_an(4'b1101, "wait_digit1_drive");
    en = 1'b0;
    @(negedge clk);
    check_output("disable_an", 32'(an), 32'h0000000F);
    check_output("disable_seg", 32'(seg), 32'h000000FF);
    check_output("disable_idx", 32'(idx), 32'h0);
    repeat (3) @(negedge clk);
    check_output("idle_an", 32'(an), 32'h0000000F);
    push_slot(70, 2'd0, 8'h7F, 0);
    en = 1'b1;
    @(negedge clk);
    check_output("restart_blank1_an", 32'(an), 32'h0000000F);
    check_output("restart_no_frame_done", 32'(fd), 32'h0);
    @(negedge clk);
    check_output("restart_blank2_an", 32'(an), 32'h0000000F);
    @(negedge clk);
    check_output("restart_drive_an", 32'(an), 32'h0000000E);
    check_output("restart_drive_seg", 32'(seg), 32'h00000080);

    // Asynchronous reset mid-slot, between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check_output("async_reset_an", 32'(an), 32'h0000000F);
    check_output("async_reset_seg", 32'(seg), 32'h000000FF);
    check_output("async_reset_idx", 32'(idx), 32'h0);
    @(negedge clk);
    push_frame(80, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 0);
    rst_n = 1'b1;
    wait_frame_done("post_reset_done", cyc);
    repeat (4) @(negedge clk);
    check_output("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Parametrised time-multiplexed seven-segment scan controller for the processor_arm display outputs, replacing fixed two-display wiring.
- Drives N_DIGITS common-anode/cathode digits from a hex value captured off the processor's debug/LED path.
- Adds frame-synchronous (tear-free) value update, inter-digit dead time, per-digit blanking, decimal points and leading-zero suppression.

Parameters:
N_DIGITS, 8, number of multiplexed digits (2..16)
REFRESH_DIV, 100000, clock cycles per digit slot (>= BLANK_CYCLES+2)
BLANK_CYCLES, 64, dead-time cycles at start of each slot with all anodes off
ANODE_ACTIVE_LOW, 1, 1: anode lines asserted low
SEG_ACTIVE_LOW, 1, 1: segment lines asserted low

Ports:
i_mclk  in  1  system clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_en  in  1  scan enable; 0 forces all digits dark
i_load  in  1  single-cycle strobe capturing i_value/i_dp/i_blank into pending register
i_value  in  4*N_DIGITS  hex nibbles, nibble k drives digit k (digit 0 = rightmost)
i_dp  in  N_DIGITS  decimal point per digit
i_blank  in  N_DIGITS  1 = digit k forced dark (segments and dp)
i_lz_suppress  in  1  leading-zero suppression mode (sampled live)
o_seg  out  8  bit0..6 = a..g, bit7 = dp, polarity per SEG_ACTIVE_LOW
o_an  out  N_DIGITS  one-hot digit select, polarity per ANODE_ACTIVE_LOW
o_digit_idx  out  $clog2(N_DIGITS)  index of digit currently in its slot
o_frame_done  out  1  one-cycle pulse as the last digit's slot ends

Behaviour:
- Reset (async assert, sync release): prescaler=0, o_digit_idx=0, state=IDLE, display and pending registers=0, pending flag=0, o_an all inactive, o_seg all off, o_frame_done=0.
- "Inactive"/"off" means logical 0 before polarity inversion; all outputs registered.
- States: IDLE, BLANK, DRIVE.
- IDLE: outputs dark; prescaler and index held at 0. i_en=1 -> BLANK next cycle with prescaler=0, index=0.
- Prescaler counts 0..REFRESH_DIV-1 per slot. BLANK while prescaler < BLANK_CYCLES (anodes inactive, segments off); DRIVE for the remainder (anode idx active, o_seg = decoded digit).
- At prescaler=REFRESH_DIV-1: prescaler->0, index increments, wraps N_DIGITS-1 -> 0; state -> BLANK.
- o_frame_done pulses in the cycle index wraps to 0.
- i_en=0 in any state -> IDLE next cycle, outputs dark that cycle; pending contents kept.
- Capture: i_load=1 copies inputs to pending and sets pending flag; a second i_load overwrites pending (last wins).
- Pending -> display copy only on entry to slot 0 (wrap, or IDLE->BLANK); flag cleared. Mid-frame loads never change the current frame.
- i_load coincident with slot-0 entry: the new value is the one copied.
- Decode (a..g as bits 0..6): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- dp bit7 = display dp[idx].
- Leading-zero suppression (i_lz_suppress=1): digit k dark-segments if nibble k and all higher nibbles are 0, for k >= 1; digit 0 never suppressed.
- Suppressed digit still shows its dp if set; anode still strobed.
- i_blank[k]=1: digit k fully dark (segments and dp), anode still strobed to keep duty uniform.
- Reset mid-frame: immediate dark outputs and all state cleared; resumes from digit 0 on release with i_en=1.

Test Plan:
(bench params: N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, both polarities active-low)
- Reset, i_en=1, load value 16'h12AF -> each slot: o_an=4'b1111 for 2 cycles, then digit0 o_an=1110 o_seg=~8'h71, digit1 ~8'h77, digit2 ~8'h5B, digit3 ~8'h06; o_frame_done every 32 cycles.
- Load 16'h0000 then 16'h5555 mid-frame at digit 2 -> digits 2,3 keep old value until wrap; next frame all digits ~8'h6D.
- i_lz_suppress=1, value 16'h0070, i_dp=4'b1000 -> digit3 o_seg=~8'h80, digit2 ~8'h00, digit1 ~8'h07, digit0 ~8'h3F.
- i_blank=4'b0100, value 16'h8888, i_dp=4'b0100 -> digit2 o_seg=8'hFF with o_an=1011 during DRIVE; others ~8'h7F.
- i_en dropped during digit1 DRIVE -> next cycle o_an=1111, o_seg=8'hFF, o_digit_idx=0; re-enable restarts at digit0 with 2 blank cycles.
- Assert i_reset_n=0 mid-slot (async, between edges) -> outputs dark immediately; display register=0, so after release (no load) digit0 shows ~8'h3F.
